// File: rtl/multi_channel_pwm.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// multi_channel_pwm
//
// NUM_CH independent PWM channels that share one period timebase. The period
// is PERIOD_STEPS steps, and each step is STEP clocks long. A channel's duty is
// given in whole steps.
//
// Duty updates are double-buffered. An accepted write lands in a per-channel
// shadow register and raises upd_pending. Every pending shadow value is copied
// into the active duty on the last cycle of the period (the boundary cycle B).
// A new duty therefore takes effect only on a period edge, which keeps the
// output free of glitches. No write is accepted on B, so a commit never races
// a write.
//
// Ports
//   clk_1MHz     in   sole clock; all logic runs on its rising edge
//   rst_n        in   asynchronous active-low reset
//   wr_valid     in   duty write request
//   wr_ready     out  write accept; low on B and while in reset
//   wr_ch        in   target channel; indices >= NUM_CH are dropped
//   wr_duty      in   new duty code, in steps
//   ch_en        in   per-channel enable; a disabled channel idles at ch_inv
//   ch_inv       in   per-channel output polarity invert
//   pwm_out      out  registered PWM outputs
//   upd_pending  out  per-channel flag: shadow duty waiting for B
//   frame_start  out  one-cycle pulse on the first cycle of each period
//   clk_div      out  50% square wave at the period rate, high in first half
//
// Cycle 0 is the clock cycle during which reset is released. Its counter value
// is 0, and the counter advances on the edge that ends it. wr_ready comes out
// of reset low, so writes can be accepted from cycle 1 onward.
// -----------------------------------------------------------------------------
module multi_channel_pwm #(
  parameter int NUM_CH       = 4,
  parameter int DUTY_W       = 4,
  parameter int STEP         = 100,
  parameter int PERIOD_STEPS = 20
) (
  input  logic              clk_1MHz,
  input  logic              rst_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [3:0]        wr_ch,
  input  logic [DUTY_W-1:0] wr_duty,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic [NUM_CH-1:0] ch_inv,
  output logic [NUM_CH-1:0] pwm_out,
  output logic [NUM_CH-1:0] upd_pending,
  output logic              frame_start,
  output logic              clk_div
);

  localparam int CNT_W = (STEP > 1) ? $clog2(STEP) : 1;
  localparam int IDX_W = (PERIOD_STEPS > 1) ? $clog2(PERIOD_STEPS) : 1;
  // The duty is compared unsigned at the wider of the two widths. Any duty at
  // or above PERIOD_STEPS then holds the output active for the whole period.
  localparam int CMP_W = (DUTY_W > IDX_W) ? DUTY_W : IDX_W;

  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(PERIOD_STEPS - 1);
  localparam logic [IDX_W-1:0] IDX_HALF  = IDX_W'(PERIOD_STEPS / 2 - 1);

  // Timebase
  logic [CNT_W-1:0] step_cnt_q, step_cnt_d;
  logic [IDX_W-1:0] step_idx_q, step_idx_d;
  logic             step_end;
  logic             at_b;
  logic             b_next;

  // Per-channel duty state
  logic [NUM_CH-1:0][DUTY_W-1:0] shadow_q, shadow_d;
  logic [NUM_CH-1:0][DUTY_W-1:0] active_q, active_d;
  logic [NUM_CH-1:0]             upd_pending_q, upd_pending_d;

  // Registered outputs
  logic [NUM_CH-1:0] pwm_out_q, pwm_out_d;
  logic              frame_start_q, frame_start_d;
  logic              clk_div_q, clk_div_d;
  logic              wr_ready_q, wr_ready_d;

  logic              wr_fire;

  // ---------------------------------------------------------------------------
  // Timebase: step_cnt counts clocks within a step, and step_idx counts steps
  // within the period.
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output is given a default before any branch, so
  // that no path can leave it unassigned and infer a latch.
  always_comb begin
    step_cnt_d = step_cnt_q + CNT_W'(1);
    step_idx_d = step_idx_q;
    step_end   = (step_cnt_q == STEP_LAST);
    at_b       = step_end && (step_idx_q == IDX_LAST);

    if (step_end) begin
      step_cnt_d = '0;
      step_idx_d = (step_idx_q == IDX_LAST) ? '0 : step_idx_q + IDX_W'(1);
    end

    // wr_ready is registered. It must therefore be computed one cycle ahead,
    // from the counter value that the next cycle will hold.
    b_next     = (step_cnt_d == STEP_LAST) && (step_idx_d == IDX_LAST);
    wr_ready_d = !b_next;

    frame_start_d = at_b;
    clk_div_d     = clk_div_q ^ (step_end &&
                                 ((step_idx_q == IDX_HALF) || (step_idx_q == IDX_LAST)));
  end

  // ---------------------------------------------------------------------------
  // Write path, commit at the boundary, and PWM compare.
  // ---------------------------------------------------------------------------
  assign wr_fire = wr_valid && wr_ready_q;

  always_comb begin
    shadow_d      = shadow_q;
    active_d      = active_q;
    upd_pending_d = upd_pending_q;
    pwm_out_d     = '0;

    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (at_b && upd_pending_q[ch]) begin
        active_d[ch]      = shadow_q[ch];
        upd_pending_d[ch] = 1'b0;
      end

      // A write to an index with no channel matches nothing here, so it is
      // dropped and no state changes.
      if (wr_fire && (wr_ch == 4'(ch))) begin
        shadow_d[ch]      = wr_duty;
        upd_pending_d[ch] = 1'b1;
      end

      // The compare uses the registered step_idx and active duty. The output
      // flop then adds the single cycle of latency.
      pwm_out_d[ch] = ch_en[ch]
                    ? ((CMP_W'(step_idx_q) < CMP_W'(active_q[ch])) ^ ch_inv[ch])
                    : ch_inv[ch];
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only. All flops then
  // sample their _d values from the same edge, whatever order the statements
  // appear in.
  always_ff @(posedge clk_1MHz or negedge rst_n) begin
    if (!rst_n) begin
      step_cnt_q    <= '0;
      step_idx_q    <= '0;
      // NOTE: the shadow and active duty arrays are cleared by reset like any
      // other flop. This is what discards writes still pending at reset, and
      // what makes every channel restart at 0% duty.
      shadow_q      <= '0;
      active_q      <= '0;
      upd_pending_q <= '0;
      pwm_out_q     <= '0;
      frame_start_q <= 1'b0;
      clk_div_q     <= 1'b1;
      wr_ready_q    <= 1'b0;
    end else begin
      step_cnt_q    <= step_cnt_d;
      step_idx_q    <= step_idx_d;
      shadow_q      <= shadow_d;
      active_q      <= active_d;
      upd_pending_q <= upd_pending_d;
      pwm_out_q     <= pwm_out_d;
      frame_start_q <= frame_start_d;
      clk_div_q     <= clk_div_d;
      wr_ready_q    <= wr_ready_d;
    end
  end

  assign wr_ready    = wr_ready_q;
  assign pwm_out     = pwm_out_q;
  assign upd_pending = upd_pending_q;
  assign frame_start = frame_start_q;
  assign clk_div     = clk_div_q;

endmodule

// File: tb/tb_multi_channel_pwm.sv
`timescale 1ns/1ps
// Directed testbench for multi_channel_pwm.
// dut uses the default parameters. dut5 has DUTY_W=5 and is used for the
// out-of-range duty cases. Both share clock, reset and stimulus; dut sees the
// low 4 bits of wr_duty.
module tb_multi_channel_pwm;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       wr_valid = 1'b0;
  logic [3:0] wr_ch = '0;
  logic [4:0] wr_duty = '0;
  logic [3:0] ch_en = '0;
  logic [3:0] ch_inv = '0;

  logic       rdy_a, fs_a, cd_a;
  logic [3:0] pwm_a, pend_a;
  logic       rdy_b, fs_b, cd_b;
  logic [3:0] pwm_b, pend_b;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc;

  int hi_a[4];
  int hi_b[4];
  int first_a[4];
  int fs_cnt, cd_hi, cd_first_low;

  multi_channel_pwm dut (
    .clk_1MHz(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(rdy_a),
    .wr_ch(wr_ch), .wr_duty(wr_duty[3:0]), .ch_en(ch_en), .ch_inv(ch_inv),
    .pwm_out(pwm_a), .upd_pending(pend_a), .frame_start(fs_a), .clk_div(cd_a)
  );

  multi_channel_pwm #(.DUTY_W(5)) dut5 (
    .clk_1MHz(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(rdy_b),
    .wr_ch(wr_ch), .wr_duty(wr_duty), .ch_en(ch_en), .ch_inv(ch_inv),
    .pwm_out(pwm_b), .upd_pending(pend_b), .frame_start(fs_b), .clk_div(cd_b)
  );

  always #5 clk = ~clk;

  // cyc is the index of the cycle currently in progress since reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, tests_run=%0d", tests_run);
    $fatal(1, "watchdog");
  end

  task automatic goto(input int n);
    int guard = 0;
    while (cyc < n && guard < 100000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != n) begin
      tests_failed++;
      $display("FAIL goto: at cycle %0d, wanted cycle %0d", cyc, n);
    end
  endtask

  task automatic do_reset(input logic [3:0] en, input logic [3:0] inv);
    @(negedge clk);
    rst_n    = 1'b0;
    wr_valid = 1'b0;
    wr_ch    = '0;
    wr_duty  = '0;
    ch_en    = en;
    ch_inv   = inv;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wr(input logic [3:0] ch, input logic [4:0] d);
    wr_valid = 1'b1;
    wr_ch    = ch;
    wr_duty  = d;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  // Samples 2000 consecutive cycles, starting at the current negedge.
  task automatic measure();
    for (int c = 0; c < 4; c++) begin
      hi_a[c] = 0; hi_b[c] = 0; first_a[c] = -1;
    end
    fs_cnt = 0; cd_hi = 0; cd_first_low = -1;
    for (int i = 0; i < 2000; i++) begin
      for (int c = 0; c < 4; c++) begin
        if (pwm_a[c]) begin
          hi_a[c]++;
          if (first_a[c] < 0) first_a[c] = i;
        end
        if (pwm_b[c]) hi_b[c]++;
      end
      if (fs_a) fs_cnt++;
      if (cd_a) cd_hi++;
      else if (cd_first_low < 0) cd_first_low = i;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    ch_en = 4'hF;
    rst_n = 1'b0;
    #2;
    tests_run++;
    if ({pwm_a, pend_a, fs_a, rdy_a, cd_a} !== {4'b0, 4'b0, 1'b0, 1'b0, 1'b1}) begin
      tests_failed++;
      $display("FAIL reset_state_a: got pwm=%b pend=%b fs=%b rdy=%b cd=%b, expected 0000 0000 0 0 1",
               pwm_a, pend_a, fs_a, rdy_a, cd_a);
    end
    tests_run++;
    if ({pwm_b, pend_b, fs_b, rdy_b, cd_b} !== {4'b0, 4'b0, 1'b0, 1'b0, 1'b1}) begin
      tests_failed++;
      $display("FAIL reset_state_b: got pwm=%b pend=%b fs=%b rdy=%b cd=%b, expected 0000 0000 0 0 1",
               pwm_b, pend_b, fs_b, rdy_b, cd_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
    goto(2);
    tests_run++;
    if ({rdy_a, cd_a, pwm_a} !== {1'b1, 1'b1, 4'b0}) begin
      tests_failed++;
      $display("FAIL reset_release: got rdy=%b cd=%b pwm=%b, expected 1 1 0000", rdy_a, cd_a, pwm_a);
    end
  endtask

  task automatic test_basic();
    do_reset(4'hF, 4'h0);
    goto(10);
    wr(4'd0, 5'd5);
    tests_run++;
    if (pend_a !== 4'b0001) begin
      tests_failed++;
      $display("FAIL basic_pend_set: got %b expected 0001", pend_a);
    end
    goto(1999);
    tests_run++;
    if ({pend_a, rdy_a, pwm_a} !== {4'b0001, 1'b0, 4'b0000}) begin
      tests_failed++;
      $display("FAIL basic_at_b: got pend=%b rdy=%b pwm=%b, expected 0001 0 0000", pend_a, rdy_a, pwm_a);
    end
    goto(2000);
    tests_run++;
    if ({pend_a, fs_a, rdy_a} !== {4'b0000, 1'b1, 1'b1}) begin
      tests_failed++;
      $display("FAIL basic_commit: got pend=%b fs=%b rdy=%b, expected 0000 1 1", pend_a, fs_a, rdy_a);
    end
    goto(2001);
    tests_run++;
    if ({fs_a, pwm_a} !== {1'b0, 4'b0001}) begin
      tests_failed++;
      $display("FAIL basic_first_high: got fs=%b pwm=%b, expected 0 0001", fs_a, pwm_a);
    end
    measure();
    tests_run++;
    if (hi_a[0] !== 500 || first_a[0] !== 0 || hi_a[1] !== 0) begin
      tests_failed++;
      $display("FAIL basic_duty5: got high=%0d first=%0d ch1_high=%0d, expected 500 0 0",
               hi_a[0], first_a[0], hi_a[1]);
    end
    tests_run++;
    if (fs_cnt !== 1 || cd_hi !== 1000 || cd_first_low !== 999) begin
      tests_failed++;
      $display("FAIL basic_timebase: got fs_pulses=%0d cd_high=%0d cd_first_low=%0d, expected 1 1000 999",
               fs_cnt, cd_hi, cd_first_low);
    end
  endtask

  task automatic test_last_wins();
    do_reset(4'hF, 4'h0);
    goto(10);
    wr(4'd1, 5'd3);
    goto(500);
    wr(4'd1, 5'd7);
    goto(700);
    wr(4'd9, 5'd15);
    wr(4'd4, 5'd15);
    tests_run++;
    if (pend_a !== 4'b0010) begin
      tests_failed++;
      $display("FAIL lastwins_pend: got %b expected 0010", pend_a);
    end
    goto(2001);
    tests_run++;
    if (pend_a !== 4'b0000) begin
      tests_failed++;
      $display("FAIL lastwins_cleared: got %b expected 0000", pend_a);
    end
    measure();
    tests_run++;
    if (hi_a[1] !== 700 || hi_a[0] !== 0 || hi_a[3] !== 0) begin
      tests_failed++;
      $display("FAIL lastwins_duty: got ch1=%0d ch0=%0d ch3=%0d, expected 700 0 0",
               hi_a[1], hi_a[0], hi_a[3]);
    end
  endtask

  task automatic test_back_to_back();
    do_reset(4'hF, 4'h0);
    goto(1999);
    wr_valid = 1'b1;
    wr_ch    = 4'd2;
    wr_duty  = 5'd6;
    tests_run++;
    if (rdy_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_ready_at_b: got %b expected 0", rdy_a);
    end
    @(negedge clk);
    tests_run++;
    if ({rdy_a, pend_a} !== {1'b1, 4'b0000}) begin
      tests_failed++;
      $display("FAIL b2b_after_b: got rdy=%b pend=%b, expected 1 0000", rdy_a, pend_a);
    end
    @(negedge clk);
    wr_valid = 1'b0;
    tests_run++;
    if (pend_a !== 4'b0100) begin
      tests_failed++;
      $display("FAIL b2b_transfer: got pend=%b expected 0100", pend_a);
    end
    measure();
    tests_run++;
    if (hi_a[2] !== 0 || pend_a !== 4'b0000) begin
      tests_failed++;
      $display("FAIL b2b_first_period: got ch2_high=%0d pend=%b, expected 0 0000", hi_a[2], pend_a);
    end
    measure();
    tests_run++;
    if (hi_a[2] !== 600) begin
      tests_failed++;
      $display("FAIL b2b_committed: got ch2_high=%0d expected 600", hi_a[2]);
    end
  endtask

  task automatic test_range();
    do_reset(4'hF, 4'b0100);
    goto(10);
    wr(4'd0, 5'd25);
    wr(4'd1, 5'd0);
    wr(4'd2, 5'd5);
    wr(4'd3, 5'd20);
    tests_run++;
    if (pend_b !== 4'b1111) begin
      tests_failed++;
      $display("FAIL range_pend: got %b expected 1111", pend_b);
    end
    goto(2001);
    measure();
    tests_run++;
    if (hi_b[0] !== 2000 || hi_b[1] !== 0 || hi_b[2] !== 1500 || hi_b[3] !== 2000) begin
      tests_failed++;
      $display("FAIL range_duty: got d25=%0d d0=%0d inv_d5=%0d d20=%0d, expected 2000 0 1500 2000",
               hi_b[0], hi_b[1], hi_b[2], hi_b[3]);
    end
  endtask

  // Continues from test_range: dut ch2 has duty 5 and is inverted.
  task automatic test_en_inv();
    goto(4100);
    tests_run++;
    if (pwm_a[2] !== 1'b0) begin
      tests_failed++;
      $display("FAIL eninv_before: got %b expected 0", pwm_a[2]);
    end
    ch_en = 4'b1011;
    @(negedge clk);
    tests_run++;
    if (pwm_a[2] !== 1'b1) begin
      tests_failed++;
      $display("FAIL eninv_disable: got %b expected 1", pwm_a[2]);
    end
    ch_inv = 4'b0000;
    @(negedge clk);
    tests_run++;
    if (pwm_a[2] !== 1'b0) begin
      tests_failed++;
      $display("FAIL eninv_uninvert: got %b expected 0", pwm_a[2]);
    end
    ch_inv = 4'b0100;
    goto(6001);
    measure();
    tests_run++;
    if (hi_a[2] !== 2000 || cd_hi !== 1000 || cd_first_low !== 999 || fs_cnt !== 1) begin
      tests_failed++;
      $display("FAIL eninv_steady: got ch2_high=%0d cd_high=%0d cd_first_low=%0d fs=%0d, expected 2000 1000 999 1",
               hi_a[2], cd_hi, cd_first_low, fs_cnt);
    end
  endtask

  task automatic test_async_reset();
    do_reset(4'hF, 4'h0);
    goto(10);
    wr(4'd0, 5'd15);
    goto(2100);
    wr(4'd1, 5'd3);
    goto(3234);
    tests_run++;
    if ({pwm_a[0], pend_a, cd_a, rdy_a} !== {1'b1, 4'b0010, 1'b0, 1'b1}) begin
      tests_failed++;
      $display("FAIL async_before: got pwm0=%b pend=%b cd=%b rdy=%b, expected 1 0010 0 1",
               pwm_a[0], pend_a, cd_a, rdy_a);
    end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({pwm_a, pend_a, cd_a, rdy_a, fs_a} !== {4'b0, 4'b0, 1'b1, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL async_immediate: got pwm=%b pend=%b cd=%b rdy=%b fs=%b, expected 0000 0000 1 0 0",
               pwm_a, pend_a, cd_a, rdy_a, fs_a);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    goto(999);
    tests_run++;
    if (cd_a !== 1'b1) begin
      tests_failed++;
      $display("FAIL async_cd_high: got %b expected 1", cd_a);
    end
    goto(1000);
    tests_run++;
    if (cd_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_cd_low: got %b expected 0", cd_a);
    end
    goto(1999);
    tests_run++;
    if ({rdy_a, pend_a} !== {1'b0, 4'b0000}) begin
      tests_failed++;
      $display("FAIL async_restart_b: got rdy=%b pend=%b, expected 0 0000", rdy_a, pend_a);
    end
    goto(2000);
    tests_run++;
    if (fs_a !== 1'b1) begin
      tests_failed++;
      $display("FAIL async_frame: got %b expected 1", fs_a);
    end
    goto(2001);
    tests_run++;
    if (pwm_a !== 4'b0000) begin
      tests_failed++;
      $display("FAIL async_active_cleared: got %b expected 0000", pwm_a);
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_basic();
    test_last_wins();
    test_back_to_back();
    test_range();
    test_en_inv();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
